ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Sits between the CPU-side requesters and the RAM controller's single request port. Arbitrates two 64-bit requesters (port 0 = instruction fetch, port 1 = data load/store) round-robin onto one read/write command interface. Owns the DRAM refresh schedule, issuing refresh commands on a fixed interval with bounded postponement. All commands are serialized; one transaction is outstanding at a time.

## Interface

**Parameters**
- REFRESH_INTERVAL, 1560: clock cycles between refresh ticks.
- MAX_PENDING, 8: refresh ticks that may be postponed before a refresh is forced.

**Ports**
- clock  in  1  system clock, rising edge.
- resetin  in  1  asynchronous, active-low reset.
- p0_req, p1_req  in  1  request level; held with fields stable until the matching pX_done.
- p0_we, p1_we  in  1  1 = write, 0 = read.
- p0_addr, p1_addr  in  64  byte address, passed through unmodified.
- p0_wdata, p1_wdata  in  64  write data.
- p0_gnt, p1_gnt  out  1  high while that port owns the RAM controller.
- p0_done, p1_done  out  1  one-cycle completion pulse.
- p0_rdata, p1_rdata  out  64  read data; valid from pX_done onward and held until the next read on that port.
- ram_address  out  64  command address.
- ram_read, ram_write  out  1  command strobes, level-held until completion.
- ram_wdata  out  64  write data to controller.
- ram_refresh  out  1  refresh command, level-held until completion.
- ram_rdata  in  64  read data from controller.
- ram_done_n  in  1  active-low completion from controller.

## Operation

- **States:** IDLE, CMD, RELEASE.
- **IDLE, choose in priority order:**
  1. Refresh, if pending == MAX_PENDING.
  2. A requester, if any pX_req is high. With both requesting, grant the port that was not granted last. The last-grant pointer resets to 1, so port 0 wins the first tie.
  3. Refresh, if pending > 0 and no request is high.
  4. Otherwise stay in IDLE.
- **IDLE to CMD:** register the choice. Drive pX_gnt, ram_address, ram_wdata, and ram_read or ram_write from pX_we, or drive ram_refresh alone with address and data 0.
- **CMD:** hold every command output stable. When ram_done_n is sampled low:
  - Capture ram_rdata into pX_rdata on reads.
  - Pulse pX_done, or decrement pending for a refresh.
  - Clear the strobes and gnt.
  - Update the last-grant pointer (not updated by refresh).
  - Go to RELEASE.
- **RELEASE:** wait for ram_done_n high, then go to IDLE. This prevents double-counting a stretched done.
- **Refresh timer:**
  - Down-counter loads REFRESH_INTERVAL-1 at reset and reloads on reaching 0.
  - Each reload is a tick: pending += 1, saturating at MAX_PENDING.
  - Tick and refresh completion in the same cycle: pending is unchanged.
  - Tick while saturated: the tick is dropped. This is a bench-checkable coverage point.
- **ram_read, ram_write, ram_refresh:** never more than one high at a time.
- **Requester drops pX_req while granted:** illegal, and the arbiter does not react. The transaction completes and the done pulse is still issued.
- **Reset, asserted asynchronously at any point, including mid-CMD:**
  - All outputs go to 0: gnt, done, rdata, strobes, ram_address, ram_wdata.
  - State goes to IDLE, pending to 0, last-grant pointer to 1, and the counter reloads.

## Timing

- Request sampled high in IDLE at edge N: strobes and gnt are high after edge N. That is 1 cycle of arbitration latency.
- ram_done_n low sampled at edge M: pX_done and rdata are valid after edge M, and strobes are low after edge M.
- Minimum gap between commands: 1 cycle in RELEASE, plus 1 cycle in IDLE.
- Back-to-back minimum transaction is 3 cycles plus controller latency.
- A forced refresh waits for at most one in-flight transaction. Worst case refresh latency from saturation is 1 transaction plus 2 cycles.

## Structure

- **Package ram_arb_pkg:**
  - state enum {IDLE, CMD, RELEASE}.
  - owner enum {OWN_P0, OWN_P1, OWN_REF}.
  - Default constants for REFRESH_INTERVAL and MAX_PENDING.
  - Width of the pending counter, $clog2(MAX_PENDING+1).
- **Sub-module ram_refresh_timer:**
  - Contains the interval counter and the saturating pending counter.
  - Inputs: clock, resetin, dec.
  - Outputs: pending_nz, pending_full.

## Test plan

- **Single read, p0:** p0 read at 0x0000_0040, controller returns 0xDEAD_BEEF_0123_4567 after 5 cycles. Then:
  - ram_read is high for exactly the CMD duration with ram_address = 0x40.
  - p0_done pulses once.
  - p0_rdata equals the returned word.
- **Contention:** p0 and p1 both request continuously. Grants alternate p0, p1, p0, p1, each followed by one RELEASE and one IDLE cycle.
- **Forced refresh:** REFRESH_INTERVAL = 16, MAX_PENDING = 2, p1 requesting back-to-back. After 32 cycles, ram_refresh is issued immediately after the current transaction ahead of p1, and pending returns to 1.
- **Idle refresh:** with no requests, a refresh is issued within 2 cycles of each tick. ram_address = 0, and ram_read/ram_write stay low.
- **Stretched done:** ram_done_n is held low for 4 cycles. Exactly one pX_done is produced, and no new command starts until ram_done_n goes high.
- **Reset mid-CMD:** resetin is pulled low while ram_write is high. All outputs are 0 asynchronously, and the first grant after release goes to p0 on a tie.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the RAM arbiter and its refresh timer.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_P0  = 2'd0,
        OWN_P1  = 2'd1,
        OWN_REF = 2'd2
    } arb_owner_e;

    localparam int DEFAULT_REFRESH_INTERVAL = 1560;
    localparam int DEFAULT_MAX_PENDING      = 8;

    // Bits needed to count postponed refresh ticks from 0 up to max_pending.
    function automatic int pending_width(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side and controller-side signals of the RAM arbiter.
// slave: the arbiter's view; master: the surrounding CPU ports and RAM controller.
interface ram_arbiter_if;

    logic        p0_req;
    logic        p1_req;
    logic        p0_we;
    logic        p1_we;
    logic [63:0] p0_addr;
    logic [63:0] p1_addr;
    logic [63:0] p0_wdata;
    logic [63:0] p1_wdata;
    logic        p0_gnt;
    logic        p1_gnt;
    logic        p0_done;
    logic        p1_done;
    logic [63:0] p0_rdata;
    logic [63:0] p1_rdata;
    logic [63:0] ram_address;
    logic        ram_read;
    logic        ram_write;
    logic [63:0] ram_wdata;
    logic        ram_refresh;
    logic [63:0] ram_rdata;
    logic        ram_done_n;

    modport slave (
        input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
        input  ram_rdata, ram_done_n,
        output p0_gnt, p1_gnt, p0_done, p1_done, p0_rdata, p1_rdata,
        output ram_address, ram_read, ram_write, ram_wdata, ram_refresh
    );

    modport master (
        output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
        output ram_rdata, ram_done_n,
        input  p0_gnt, p1_gnt, p0_done, p1_done, p0_rdata, p1_rdata,
        input  ram_address, ram_read, ram_write, ram_wdata, ram_refresh
    );

endinterface

// File: rtl/ram_arbiter_refresh_timer.sv
// Refresh schedule: interval down-counter plus saturating count of
// postponed refresh ticks, decremented when a refresh completes.
module ram_refresh_timer
    import ram_arb_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL,
    parameter int MAX_PENDING      = DEFAULT_MAX_PENDING
) (
    input  logic clock,
    input  logic resetin,
    input  logic dec,
    output logic pending_nz,
    output logic pending_full
);

    localparam int PW = pending_width(MAX_PENDING);
    localparam int CW = $clog2(REFRESH_INTERVAL + 1);
    localparam logic [CW-1:0] RELOAD   = CW'(REFRESH_INTERVAL - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    logic [CW-1:0] count;
    logic [PW-1:0] pending;
    logic          tick;

    assign tick = (count == '0);

    // Count down each cycle; reaching zero reloads and marks a refresh tick.
    always_ff @(posedge clock or negedge resetin) begin
        if (!resetin) begin
            count <= RELOAD;
        end else if (tick) begin
            count <= RELOAD;
        end else begin
            count <= count - CW'(1);
        end
    end

    // Ticks add work, completed refreshes remove it; both at once cancel and a tick at the cap is dropped.
    always_ff @(posedge clock or negedge resetin) begin
        if (!resetin) begin
            pending <= '0;
        end else begin
            case ({tick, dec})
                2'b10: if (pending != PEND_MAX) pending <= pending + PW'(1);
                2'b01: if (pending != '0)       pending <= pending - PW'(1);
                default: ;
            endcase
        end
    end

    assign pending_nz   = (pending != '0);
    assign pending_full = (pending == PEND_MAX);

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter of two 64-bit requesters onto a single RAM command
// port, interleaving DRAM refreshes with bounded postponement.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL,
    parameter int MAX_PENDING      = DEFAULT_MAX_PENDING
) (
    input  logic         clock,
    input  logic         resetin,
    ram_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE    = 2'(IDLE);
    localparam logic [1:0] ST_CMD     = 2'(CMD);
    localparam logic [1:0] ST_RELEASE = 2'(RELEASE);
    localparam logic [1:0] OW_P0      = 2'(OWN_P0);
    localparam logic [1:0] OW_P1      = 2'(OWN_P1);
    localparam logic [1:0] OW_REF     = 2'(OWN_REF);

    logic [1:0]  state;
    logic [1:0]  owner;
    logic        last_p1;
    logic        pick_p1;
    logic        any_req;
    logic        take_refresh;
    logic        ref_dec;
    logic        pending_nz;
    logic        pending_full;
    logic        sel_we;
    logic [63:0] sel_addr;
    logic [63:0] sel_wdata;

    // On a tie hand the bus to the port that did not have it last time.
    always_comb begin
        pick_p1 = bus.p1_req;
        if (bus.p0_req && bus.p1_req) begin
            pick_p1 = ~last_p1;
        end
    end

    assign any_req      = bus.p0_req | bus.p1_req;
    assign take_refresh = pending_full | (~any_req & pending_nz);
    assign sel_we       = pick_p1 ? bus.p1_we    : bus.p0_we;
    assign sel_addr     = pick_p1 ? bus.p1_addr  : bus.p0_addr;
    assign sel_wdata    = pick_p1 ? bus.p1_wdata : bus.p0_wdata;
    assign ref_dec      = (state == ST_CMD) && !bus.ram_done_n && (owner == OW_REF);

    ram_refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL),
        .MAX_PENDING     (MAX_PENDING)
    ) u_timer (
        .clock       (clock),
        .resetin     (resetin),
        .dec         (ref_dec),
        .pending_nz  (pending_nz),
        .pending_full(pending_full)
    );

    // Command sequencer: pick in IDLE, hold in CMD until done, wait out done in RELEASE.
    always_ff @(posedge clock or negedge resetin) begin
        if (!resetin) begin
            state           <= ST_IDLE;
            owner           <= OW_P0;
            last_p1         <= 1'b1;
            bus.p0_gnt      <= 1'b0;
            bus.p1_gnt      <= 1'b0;
            bus.p0_done     <= 1'b0;
            bus.p1_done     <= 1'b0;
            bus.p0_rdata    <= '0;
            bus.p1_rdata    <= '0;
            bus.ram_address <= '0;
            bus.ram_wdata   <= '0;
            bus.ram_read    <= 1'b0;
            bus.ram_write   <= 1'b0;
            bus.ram_refresh <= 1'b0;
        end else begin
            bus.p0_done <= 1'b0;
            bus.p1_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take_refresh) begin
                        owner           <= OW_REF;
                        bus.ram_refresh <= 1'b1;
                        bus.ram_address <= '0;
                        bus.ram_wdata   <= '0;
                        state           <= ST_CMD;
                    end else if (any_req) begin
                        owner           <= pick_p1 ? OW_P1 : OW_P0;
                        bus.p0_gnt      <= ~pick_p1;
                        bus.p1_gnt      <= pick_p1;
                        bus.ram_address <= sel_addr;
                        bus.ram_wdata   <= sel_wdata;
                        bus.ram_read    <= ~sel_we;
                        bus.ram_write   <= sel_we;
                        state           <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (!bus.ram_done_n) begin
                        case (owner)
                            OW_P0: begin
                                bus.p0_done <= 1'b1;
                                if (bus.ram_read) bus.p0_rdata <= bus.ram_rdata;
                                last_p1 <= 1'b0;
                            end
                            OW_P1: begin
                                bus.p1_done <= 1'b1;
                                if (bus.ram_read) bus.p1_rdata <= bus.ram_rdata;
                                last_p1 <= 1'b1;
                            end
                            default: ;
                        endcase
                        bus.p0_gnt      <= 1'b0;
                        bus.p1_gnt      <= 1'b0;
                        bus.ram_read    <= 1'b0;
                        bus.ram_write   <= 1'b0;
                        bus.ram_refresh <= 1'b0;
                        state           <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (bus.ram_done_n) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised bench for ram_arbiter against a transaction-level reference
// model; the bench also plays the RAM controller and both requesters.
module tb_ram_arbiter;

    localparam int          RI        = 16;
    localparam int          MP        = 2;
    localparam logic [63:0] READ_WORD = 64'hDEAD_BEEF_0123_4567;

    logic clock   = 1'b0;
    logic resetin = 1'b0;

    ram_arbiter_if bus ();

    ram_arbiter #(.REFRESH_INTERVAL(RI), .MAX_PENDING(MP)) dut (
        .clock  (clock),
        .resetin(resetin),
        .bus    (bus.slave)
    );

    // Free-running 10-time-unit clock.
    always #5 clock = ~clock;

    int checks_total  = 0;
    int checks_passed = 0;

    int  m_cycle, m_pending, m_owner, m_age, m_lat, m_stretch, dropped_ticks;
    bit  m_last_p1, m_active, m_release;
    logic        e_gnt0, e_gnt1, e_done0, e_done1, e_read, e_write, e_ref;
    logic [63:0] e_rd0, e_rd1, e_addr, e_wdata;

    int ctrl_low_left, force_lat, force_stretch, pct0, pct1;
    bit use_fixed_rdata;

    int   cnt_done0, cnt_done1, cnt_read, cnt_bad_ref, n_ref, first_ref;
    logic prev_ref, prev_g0, prev_g1;
    int   grant_q[$];
    int   alt_viol;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all();
        check_output("p0_gnt", 64'(bus.p0_gnt), 64'(e_gnt0));
        check_output("p1_gnt", 64'(bus.p1_gnt), 64'(e_gnt1));
        check_output("p0_done", 64'(bus.p0_done), 64'(e_done0));
        check_output("p1_done", 64'(bus.p1_done), 64'(e_done1));
        check_output("p0_rdata", bus.p0_rdata, e_rd0);
        check_output("p1_rdata", bus.p1_rdata, e_rd1);
        check_output("ram_read", 64'(bus.ram_read), 64'(e_read));
        check_output("ram_write", 64'(bus.ram_write), 64'(e_write));
        check_output("ram_refresh", 64'(bus.ram_refresh), 64'(e_ref));
        check_output("ram_address", bus.ram_address, e_addr);
        check_output("ram_wdata", bus.ram_wdata, e_wdata);
        check_output("strobe_onehot",
                     64'($countones({bus.ram_read, bus.ram_write, bus.ram_refresh}) <= 1), 64'd1);
    endtask

    task automatic model_reset();
        m_cycle = 0; m_pending = 0; m_last_p1 = 1'b1;
        m_active = 1'b0; m_release = 1'b0; m_owner = 0; m_age = 0;
        e_gnt0 = 0; e_gnt1 = 0; e_done0 = 0; e_done1 = 0;
        e_read = 0; e_write = 0; e_ref = 0;
        e_rd0 = '0; e_rd1 = '0; e_addr = '0; e_wdata = '0;
        ctrl_low_left = 0;
    endtask

    task automatic start_cmd(input int who);
        m_active  = 1'b1;
        m_owner   = who;
        m_age     = 0;
        m_lat     = (force_lat > 0) ? force_lat : int'($urandom_range(6, 1));
        m_stretch = (force_stretch > 0) ? force_stretch : int'($urandom_range(3, 1));
        if (who == 2) begin
            e_ref = 1; e_addr = '0; e_wdata = '0;
        end else if (who == 0) begin
            e_gnt0 = 1; e_addr = bus.p0_addr; e_wdata = bus.p0_wdata;
            e_write = bus.p0_we; e_read = !bus.p0_we;
        end else begin
            e_gnt1 = 1; e_addr = bus.p1_addr; e_wdata = bus.p1_wdata;
            e_write = bus.p1_we; e_read = !bus.p1_we;
        end
    endtask

    // One clock edge of the reference: a transaction is either running,
    // draining a stretched done, or the bus is free and the next job is chosen.
    task automatic model_edge();
        bit tick;
        bit dec;
        int pick;
        dec = 1'b0;
        e_done0 = 0; e_done1 = 0;
        if (!bus.ram_done_n && ctrl_low_left > 0) ctrl_low_left--;
        if (m_release) begin
            if (bus.ram_done_n) m_release = 1'b0;
        end else if (m_active) begin
            m_age++;
            if (!bus.ram_done_n) begin
                if (m_owner == 0) begin
                    e_done0 = 1; if (e_read) e_rd0 = bus.ram_rdata; m_last_p1 = 1'b0;
                end else if (m_owner == 1) begin
                    e_done1 = 1; if (e_read) e_rd1 = bus.ram_rdata; m_last_p1 = 1'b1;
                end else begin
                    dec = 1'b1;
                end
                e_gnt0 = 0; e_gnt1 = 0; e_read = 0; e_write = 0; e_ref = 0;
                m_active = 1'b0; m_release = 1'b1;
            end
        end else begin
            pick = -1;
            if (m_pending == MP)                 pick = 2;
            else if (bus.p0_req && bus.p1_req)   pick = m_last_p1 ? 0 : 1;
            else if (bus.p0_req)                 pick = 0;
            else if (bus.p1_req)                 pick = 1;
            else if (m_pending > 0)              pick = 2;
            if (pick >= 0) start_cmd(pick);
        end
        m_cycle++;
        tick = ((m_cycle % RI) == 0);
        if (tick && !dec) begin
            if (m_pending < MP) m_pending++;
            else dropped_ticks++;
        end else if (dec && !tick) begin
            m_pending--;
        end
    endtask

    task automatic new_p0();
        bus.p0_req = 1'b1; bus.p0_we = 1'($urandom_range(1, 0));
        bus.p0_addr = {$urandom, $urandom}; bus.p0_wdata = {$urandom, $urandom};
    endtask

    task automatic new_p1();
        bus.p1_req = 1'b1; bus.p1_we = 1'($urandom_range(1, 0));
        bus.p1_addr = {$urandom, $urandom}; bus.p1_wdata = {$urandom, $urandom};
    endtask

    task automatic drive_requesters();
        if (bus.p0_req && e_done0) begin
            if (int'($urandom_range(99, 0)) < pct0) new_p0(); else bus.p0_req = 1'b0;
        end else if (!bus.p0_req && int'($urandom_range(99, 0)) < pct0) begin
            new_p0();
        end
        if (bus.p1_req && e_done1) begin
            if (int'($urandom_range(99, 0)) < pct1) new_p1(); else bus.p1_req = 1'b0;
        end else if (!bus.p1_req && int'($urandom_range(99, 0)) < pct1) begin
            new_p1();
        end
    endtask

    task automatic drive_controller();
        if (ctrl_low_left > 0) begin
            bus.ram_done_n = 1'b0;
        end else if (m_active && (m_age + 1 >= m_lat)) begin
            ctrl_low_left  = m_stretch;
            bus.ram_done_n = 1'b0;
            bus.ram_rdata  = use_fixed_rdata ? READ_WORD : {$urandom, $urandom};
        end else begin
            bus.ram_done_n = 1'b1;
            bus.ram_rdata  = {$urandom, $urandom};
        end
    endtask

    task automatic observe();
        if (bus.p0_done) cnt_done0++;
        if (bus.p1_done) cnt_done1++;
        if (bus.ram_read) cnt_read++;
        if (bus.ram_refresh && (bus.ram_read || bus.ram_write || bus.ram_address != '0))
            cnt_bad_ref++;
        if (bus.ram_refresh && !prev_ref) begin
            n_ref++;
            if (first_ref == 0) first_ref = m_cycle;
        end
        if (bus.p0_gnt && !prev_g0) grant_q.push_back(0);
        if (bus.p1_gnt && !prev_g1) grant_q.push_back(1);
        prev_ref = bus.ram_refresh; prev_g0 = bus.p0_gnt; prev_g1 = bus.p1_gnt;
    endtask

    task automatic clear_obs();
        cnt_done0 = 0; cnt_done1 = 0; cnt_read = 0; cnt_bad_ref = 0;
        n_ref = 0; first_ref = 0; grant_q.delete();
    endtask

    // One clock: model the edge, check at the falling edge, then drive the next inputs.
    task automatic apply_stimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            model_edge();
            @(negedge clock);
            check_all();
            observe();
            drive_requesters();
            drive_controller();
        end
    endtask

    task automatic do_reset();
        resetin = 1'b0;
        bus.p0_req = 1'b0; bus.p1_req = 1'b0; bus.ram_done_n = 1'b1;
        model_reset();
        @(negedge clock); check_all();
        @(negedge clock); check_all();
        prev_ref = 0; prev_g0 = 0; prev_g1 = 0;
        resetin = 1'b1;
    endtask

    initial begin
        bus.p0_req = 0; bus.p1_req = 0; bus.p0_we = 0; bus.p1_we = 0;
        bus.p0_addr = '0; bus.p1_addr = '0; bus.p0_wdata = '0; bus.p1_wdata = '0;
        bus.ram_rdata = '0; bus.ram_done_n = 1'b1;
        force_lat = 0; force_stretch = 0; pct0 = 0; pct1 = 0;
        use_fixed_rdata = 0; dropped_ticks = 0;
        clear_obs();

        // Reset values, then a single p0 read answered after 5 cycles.
        do_reset();
        force_lat = 5; force_stretch = 1; use_fixed_rdata = 1;
        bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 64'h40; bus.p0_wdata = '0;
        clear_obs();
        apply_stimulus(10);
        use_fixed_rdata = 0;
        check_output("single_read_rdata", bus.p0_rdata, READ_WORD);
        check_output("single_read_done_count", 64'(cnt_done0), 64'd1);
        check_output("single_read_cmd_cycles", 64'(cnt_read), 64'd5);

        // Both ports requesting without pause: grants must alternate.
        $display("[TB] contention");
        force_lat = 2; pct0 = 100; pct1 = 100;
        new_p0(); new_p1();
        clear_obs();
        apply_stimulus(40);
        alt_viol = 0;
        for (int i = 1; i < grant_q.size(); i++) if (grant_q[i] == grant_q[i-1]) alt_viol++;
        check_output("contention_alternation", 64'(alt_viol), 64'd0);
        check_output("contention_grants_ge6", 64'(grant_q.size() >= 6), 64'd1);

        // p1 back-to-back from reset: second tick saturates and forces a refresh.
        $display("[TB] forced refresh");
        pct0 = 0; pct1 = 0;
        do_reset();
        force_lat = 3; pct1 = 100;
        new_p1();
        clear_obs();
        apply_stimulus(45);
        check_output("forced_refresh_window", 64'(first_ref >= 33 && first_ref <= 37), 64'd1);

        // Quiet bus: refreshes run on their own with address 0 and no read/write.
        $display("[TB] idle refresh");
        pct1 = 0;
        apply_stimulus(12);
        clear_obs();
        apply_stimulus(40);
        check_output("idle_refresh_count_ge2", 64'(n_ref >= 2), 64'd1);
        check_output("idle_refresh_clean", 64'(cnt_bad_ref), 64'd0);
        check_output("idle_no_reads", 64'(cnt_read), 64'd0);

        // Completion held low for 4 cycles yields exactly one done.
        $display("[TB] stretched done");
        force_lat = 2; force_stretch = 4;
        new_p0();
        clear_obs();
        apply_stimulus(15);
        check_output("stretched_done_count", 64'(cnt_done0), 64'd1);

        // Very long transaction so refresh ticks pile up past the cap.
        $display("[TB] long transaction");
        force_stretch = 1; force_lat = 45;
        new_p1();
        apply_stimulus(60);
        $display("[TB] dropped refresh ticks so far: %0d", dropped_ticks);

        // Random traffic with random controller latency and done stretch.
        $display("[TB] random traffic");
        force_lat = 0; force_stretch = 0; pct0 = 30; pct1 = 30;
        apply_stimulus(300);
        pct0 = 0; pct1 = 0;
        apply_stimulus(40);

        // Asynchronous reset in the middle of a write.
        $display("[TB] reset mid-command");
        force_lat = 20;
        new_p1(); bus.p1_we = 1'b1;
        for (int i = 0; i < 40 && !bus.ram_write; i++) apply_stimulus(1);
        check_output("reset_write_seen", 64'(bus.ram_write), 64'd1);
        #2;
        resetin = 1'b0;
        #1;
        model_reset();
        check_all();
        force_lat = 2;
        new_p0(); new_p1();
        bus.ram_done_n = 1'b1;
        @(negedge clock);
        check_all();
        prev_ref = 0; prev_g0 = 0; prev_g1 = 0;
        resetin = 1'b1;
        apply_stimulus(1);
        check_output("reset_tie_p0_gnt", 64'(bus.p0_gnt), 64'd1);
        check_output("reset_tie_p1_gnt", 64'(bus.p1_gnt), 64'd0);
        apply_stimulus(20);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
